// File: rtl/ln_horner_seq_if.sv
// Handshake bundle for the sequential ln(y) evaluator: operand in, result out.
interface ln_horner_seq_if #(
  parameter int WIDTHIN  = 32,
  parameter int WIDTHOUT = 16
);
  logic                i_valid;
  logic                o_ready;
  logic [WIDTHIN-1:0]  i_y;
  logic                o_valid;
  logic                i_ready;
  logic [WIDTHOUT-1:0] o_x;
  logic                o_err;

  modport slave (
    input  i_valid, i_y, i_ready,
    output o_ready, o_valid, o_x, o_err
  );

  modport master (
    output i_valid, i_y, i_ready,
    input  o_ready, o_valid, o_x, o_err
  );
endinterface

// File: rtl/ln_horner_seq.sv
// Sequential ln(y): normalise y = 2^k * (1+t), evaluate a 5-term ln(1+t) series by
// Horner's rule on one shared multiplier, then add k*ln(2). Q7.25 in, Q4.12 out.
module ln_horner_seq (
  input  logic             clk,
  input  logic             reset,
  ln_horner_seq_if.slave   bus
);

  localparam logic signed [31:0] C1  = 32'sh0200_0000;
  localparam logic signed [31:0] C2  = 32'shFF00_0000;
  localparam logic signed [31:0] C3  = 32'sh00AA_AAAB;
  localparam logic signed [31:0] C4  = 32'shFF80_0000;
  localparam logic signed [31:0] C5  = 32'sh0066_6666;
  localparam logic signed [31:0] LN2 = 32'sh0162_E430;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_NORM = 3'd1,
    S_MUL  = 3'd2,
    S_LN2  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] y_q, y_d;
  logic [5:0]  k_q, k_d;
  logic [15:0] t_q, t_d;
  logic [31:0] acc_q, acc_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [15:0] x_q, x_d;
  logic        err_q, err_d;
  logic        ready_q, ready_d;
  logic        valid_q, valid_d;

  logic [4:0]         p_s;
  logic [31:0]        sh_s;
  logic [31:0]        coef_s;
  logic [31:0]        kln2_s;
  logic [31:0]        r_s;
  logic signed [31:0] shr_s;
  logic [15:0]        sat_s;

  // State register and datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      y_q     <= 32'd0;
      k_q     <= 6'd0;
      t_q     <= 16'd0;
      acc_q   <= 32'd0;
      cnt_q   <= 3'd0;
      x_q     <= 16'd0;
      err_q   <= 1'b0;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      y_q     <= y_d;
      k_q     <= k_d;
      t_q     <= t_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
      err_q   <= err_d;
      ready_q <= ready_d;
      valid_q <= valid_d;
    end
  end

  // Next-state logic and arithmetic for normalise / Horner step / ln2 correction
  always_comb begin
    state_d = state_q;
    y_d     = y_q;
    k_d     = k_q;
    t_d     = t_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    x_d     = x_q;
    err_d   = err_q;

    p_s = 5'd0;
    for (int i = 0; i < 32; i++) begin
      if (y_q[i]) begin
        p_s = 5'(i);
      end else begin
        p_s = p_s;
      end
    end

    // Both operands widened to 49 bits so the low 49 product bits equal the signed product.
    sh_s = 32'(({{17{acc_q[31]}}, acc_q} * {33'd0, t_q}) >> 16);

    case (cnt_q)
      3'd0:    coef_s = C4;
      3'd1:    coef_s = C3;
      3'd2:    coef_s = C2;
      3'd3:    coef_s = C1;
      default: coef_s = 32'd0;
    endcase

    kln2_s = {{26{k_q[5]}}, k_q} * LN2;
    r_s    = acc_q + kln2_s;
    shr_s  = $signed(r_s) >>> 13;
    if (shr_s[31:15] == {17{shr_s[31]}}) begin
      sat_s = shr_s[15:0];
    end else if (shr_s[31]) begin
      sat_s = 16'h8000;
    end else begin
      sat_s = 16'h7FFF;
    end

    case (state_q)
      S_IDLE: begin
        if (bus.i_valid) begin
          y_d     = bus.i_y;
          state_d = S_NORM;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_NORM: begin
        if (y_q == 32'd0) begin
          err_d   = 1'b1;
          x_d     = 16'h8000;
          state_d = S_DONE;
        end else begin
          err_d   = 1'b0;
          k_d     = {1'b0, p_s} - 6'd25;
          // Fraction bits just below the leading one, zero-filled for small p.
          t_d     = 16'({y_q, 16'h0000} >> p_s);
          acc_d   = C5;
          cnt_d   = 3'd0;
          state_d = S_MUL;
        end
      end
      S_MUL: begin
        if (cnt_q == 3'd4) begin
          acc_d   = sh_s;
          state_d = S_LN2;
        end else begin
          acc_d   = sh_s + coef_s;
          cnt_d   = cnt_q + 3'd1;
          state_d = S_MUL;
        end
      end
      S_LN2: begin
        x_d     = sat_s;
        state_d = S_DONE;
      end
      S_DONE: begin
        if (bus.i_ready) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_DONE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    ready_d = (state_d == S_IDLE);
    valid_d = (state_d == S_DONE);
  end

  assign bus.o_ready = ready_q;
  assign bus.o_valid = valid_q;
  assign bus.o_x     = x_q;
  assign bus.o_err   = err_q;

endmodule

// File: tb/tb_ln_horner_seq.sv
// Directed and random checks of ln_horner_seq against an integer reference of the
// normalise / Horner / k*ln2 arithmetic.
module tb_ln_horner_seq;

  localparam int C1  = 32'sh0200_0000;
  localparam int C2  = 32'shFF00_0000;
  localparam int C3  = 32'sh00AA_AAAB;
  localparam int C4  = 32'shFF80_0000;
  localparam int C5  = 32'sh0066_6666;
  localparam int LN2 = 32'sh0162_E430;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  ln_horner_seq_if bus ();

  ln_horner_seq dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // ln(y) computed from y = 2^k*(1+t): truncated Taylor series in Horner form, 32-bit wrap.
  function automatic logic [15:0] ref_ln(input logic [31:0] y, output bit err);
    longint yy, t, acc, prod, r, x;
    longint coef [5];
    int p, k;
    coef[0] = C4; coef[1] = C3; coef[2] = C2; coef[3] = C1; coef[4] = 0;
    if (y == 32'd0) begin
      err = 1'b1;
      return 16'h8000;
    end
    err = 1'b0;
    yy  = longint'(y);
    p   = 0;
    while ((longint'(1) << (p + 1)) <= yy) p++;
    k   = p - 25;
    t   = ((yy - (longint'(1) << p)) << 16) >> p;
    acc = C5;
    for (int i = 0; i < 5; i++) begin
      prod = acc * t;
      acc  = longint'(int'(prod >>> 16)) + coef[i];
      acc  = longint'(int'(acc));
    end
    r = longint'(int'(acc + longint'(k) * LN2));
    x = r >>> 13;
    if (x > 32767)  return 16'h7FFF;
    if (x < -32768) return 16'h8000;
    return 16'(x);
  endfunction

  // One full transaction: accept, wait for result, optional back-pressure, then drain.
  task automatic run_op(input logic [31:0] y, input string tag, input int hold,
                        output logic [15:0] obs_x);
    logic [15:0] ex;
    bit          ee;
    int          lat;
    int          exp_lat;
    ex      = ref_ln(y, ee);
    exp_lat = ee ? 1 : 7;
    @(negedge clk);
    check({tag, " ready_idle"}, 32'(bus.o_ready), 32'd1);
    bus.i_valid = 1'b1;
    bus.i_y     = y;
    @(posedge clk);
    #1;
    // Operand changes and a still-asserted i_valid must not disturb the operation.
    bus.i_y = $urandom;
    lat = 0;
    while (!bus.o_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    bus.i_valid = 1'b0;
    check({tag, " latency"}, 32'(lat), 32'(exp_lat));
    check({tag, " o_x"}, 32'(bus.o_x), 32'(ex));
    check({tag, " o_err"}, 32'(bus.o_err), 32'(ee));
    check({tag, " ready_busy"}, 32'(bus.o_ready), 32'd0);
    obs_x = bus.o_x;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({tag, " hold_valid"}, 32'(bus.o_valid), 32'd1);
      check({tag, " hold_x"}, 32'(bus.o_x), 32'(obs_x));
      check({tag, " hold_ready"}, 32'(bus.o_ready), 32'd0);
    end
    @(negedge clk);
    bus.i_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.i_ready = 1'b0;
    check({tag, " drained_valid"}, 32'(bus.o_valid), 32'd0);
    check({tag, " drained_ready"}, 32'(bus.o_ready), 32'd1);
  endtask

  initial begin
    logic [15:0] xo;
    logic [31:0] ry;
    n_checks    = 0;
    n_fail      = 0;
    reset       = 1'b1;
    bus.i_valid = 1'b0;
    bus.i_y     = 32'd0;
    bus.i_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst o_ready", 32'(bus.o_ready), 32'd1);
    check("rst o_valid", 32'(bus.o_valid), 32'd0);
    check("rst o_x", 32'(bus.o_x), 32'd0);
    check("rst o_err", 32'(bus.o_err), 32'd0);
    reset = 1'b0;

    run_op(32'h0200_0000, "one", 0, xo);
    check("one spec", 32'(xo), 32'h0000);
    run_op(32'h0400_0000, "two", 0, xo);
    check("two spec", 32'(xo), 32'h0B17);
    run_op(32'h0100_0000, "half", 0, xo);
    check("half spec", 32'(xo), 32'hF4E8);
    run_op(32'h0300_0000, "onehalf", 0, xo);
    check("onehalf spec", 32'(xo), 32'h0684);
    run_op(32'h0000_0000, "zero", 0, xo);
    check("zero spec", 32'(xo), 32'h8000);
    run_op(32'h0200_0000, "after_zero", 0, xo);
    run_op(32'h0000_0001, "tiny_sat", 0, xo);
    check("tiny_sat spec", 32'(xo), 32'h8000);
    run_op(32'hFFFF_FFFF, "max", 0, xo);
    run_op(32'h0400_0000, "hold", 20, xo);

    // Abort in the middle of the multiply loop (cnt = 2).
    @(negedge clk);
    bus.i_valid = 1'b1;
    bus.i_y     = 32'h0300_0000;
    @(posedge clk);
    #1;
    bus.i_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    check("midrst o_valid", 32'(bus.o_valid), 32'd0);
    check("midrst o_ready", 32'(bus.o_ready), 32'd1);
    check("midrst o_x", 32'(bus.o_x), 32'd0);
    reset = 1'b0;
    run_op(32'h0400_0000, "post_rst", 0, xo);
    check("post_rst spec", 32'(xo), 32'h0B17);

    for (int n = 0; n < 40; n++) begin
      ry = $urandom;
      ry = ry >> $urandom_range(0, 31);
      run_op(ry, "random", n % 7, xo);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
